// File: rtl/sdc_pkg.sv
// Shared types and width helpers for the SDC supervisor.
package sdc_pkg;

  typedef enum logic [2:0] {
    INIT         = 3'd0,
    WAIT_HEALTHY = 3'd1,
    ARMED        = 3'd2,
    CLOSED       = 3'd3,
    TRIPPED      = 3'd4
  } sdc_state_t;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    LOOP    = 3'd1,
    WDOG    = 3'd2,
    MODE    = 3'd3,
    AS_OPEN = 3'd4
  } sdc_cause_t;

  localparam int STATE_W    = 3;
  localparam int CAUSE_W    = 3;
  localparam int TRIP_CNT_W = 8;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdc_debounce.sv
// Asymmetric loop filter: a low clears at once, a high must persist
// DEBOUNCE_CYC consecutive cycles before the filtered bit sets.
module sdc_debounce import sdc_pkg::*; #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam int CW = cnt_w(DEBOUNCE_CYC);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      filtered <= 1'b0;
    end else if (!raw) begin
      count    <= '0;
      filtered <= 1'b0;
    end else if (count == LAST) begin
      filtered <= 1'b1;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/sdc_supervisor.sv
// SDC relay supervisor: loop/watchdog supervision, button qualification, sticky trip.
// Optional fault logging (First_fault_loop, Trip_count) under macro SDC_FAULT_LOG_EN.
module sdc_supervisor import sdc_pkg::*; #(
  parameter int N_LOOPS        = 4,
  parameter int DEBOUNCE_CYC   = 16,
  parameter int WD_TIMEOUT_CYC = 1000,
  parameter int ACT_HOLD_CYC   = 8
) (
  input  logic                 clk,
  input  logic                 Power_on_Reset,
  input  logic                 AS_close_SDC,
  input  logic                 AS_driving_mode,
  input  logic                 TS_Activation_Button_cockpit,
  input  logic                 TS_Activation_Button_external,
  input  logic                 Watchdog,
  input  logic [N_LOOPS-1:0]   Shutdown_circuit,
  output logic                 To_SDC_relais,
  output logic                 SDC_is_Ready,
  output logic [STATE_W-1:0]   SDC_state,
  output logic [CAUSE_W-1:0]   Trip_cause
`ifdef SDC_FAULT_LOG_EN
  ,
  output logic [cnt_w(N_LOOPS)-1:0] First_fault_loop,
  output logic [TRIP_CNT_W-1:0]     Trip_count
`endif
);

  localparam int SW  = 5 + N_LOOPS;
  localparam int WDW = cnt_w(WD_TIMEOUT_CYC + 1);
  localparam int HW  = cnt_w(ACT_HOLD_CYC);
  localparam logic [WDW-1:0] WD_LIMIT  = WDW'(WD_TIMEOUT_CYC);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(ACT_HOLD_CYC - 1);

  logic [SW-1:0]      sync1, sync2;
  logic               close_s, mode_s, cockpit_s, ext_s, wd_s;
  logic [N_LOOPS-1:0] loops_s, loops_f;
  logic               loops_ok, wd_ok, healthy;
  logic               wd_prev;
  logic [WDW-1:0]     wd_count;
  logic [1:0]         primed;
  logic               act, released, hold_active, activate;
  logic [HW-1:0]      hold_count;
  logic               mode_cap;
  logic               trip_now, close_now;
  sdc_state_t         state, next_state;
  sdc_cause_t         fault_cause, trip_cause;

  always_ff @(posedge clk) begin
    if (Power_on_Reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {Shutdown_circuit, Watchdog, TS_Activation_Button_external,
                TS_Activation_Button_cockpit, AS_driving_mode, AS_close_SDC};
      sync2 <= sync1;
    end
  end

  assign close_s   = sync2[0];
  assign mode_s    = sync2[1];
  assign cockpit_s = sync2[2];
  assign ext_s     = sync2[3];
  assign wd_s      = sync2[4];
  assign loops_s   = sync2[SW-1:5];

  for (genvar i = 0; i < N_LOOPS; i++) begin : g_loop
    sdc_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
      .clk      (clk),
      .reset    (Power_on_Reset),
      .raw      (loops_s[i]),
      .filtered (loops_f[i])
    );
  end

  assign loops_ok = &loops_f;

  always_ff @(posedge clk) begin
    if (Power_on_Reset) begin
      wd_prev  <= 1'b0;
      wd_count <= '0;
    end else begin
      wd_prev <= wd_s;
      if (wd_s != wd_prev)
        wd_count <= '0;
      else if (wd_count < WD_LIMIT)
        wd_count <= wd_count + WDW'(1);
    end
  end

  assign wd_ok   = (wd_count < WD_LIMIT);
  assign healthy = loops_ok & wd_ok;

  assign act         = mode_s ? ext_s : cockpit_s;
  assign hold_active = (state == ARMED) && released && act && close_s;
  assign activate    = hold_active && (hold_count == HOLD_LAST);
  assign close_now   = (state == ARMED) && (next_state == CLOSED);
  assign trip_now    = (state == CLOSED) && (next_state == TRIPPED);

  // Synchroniser outputs are still reset zeros for two cycles; a button
  // held through reset must not be mistaken for a release.
  always_ff @(posedge clk) begin
    if (Power_on_Reset) begin
      primed     <= 2'b00;
      released   <= 1'b0;
      hold_count <= '0;
    end else begin
      primed <= {primed[0], 1'b1};
      if (close_now)
        released <= 1'b0;
      else if (primed[1] && !act && (state == WAIT_HEALTHY || state == ARMED))
        released <= 1'b1;
      if (!hold_active)
        hold_count <= '0;
      else if (hold_count != HOLD_LAST)
        hold_count <= hold_count + HW'(1);
    end
  end

  always_comb begin
    fault_cause = NONE;
    if (!loops_ok)
      fault_cause = LOOP;
    else if (!wd_ok)
      fault_cause = WDOG;
    else if (mode_s != mode_cap)
      fault_cause = MODE;
    else if (!close_s)
      fault_cause = AS_OPEN;
  end

  always_comb begin
    next_state = state;
    case (state)
      INIT:         next_state = WAIT_HEALTHY;
      WAIT_HEALTHY: if (healthy) next_state = ARMED;
      ARMED: begin
        if (!healthy)
          next_state = WAIT_HEALTHY;
        else if (activate)
          next_state = CLOSED;
      end
      CLOSED:       if (fault_cause != NONE) next_state = TRIPPED;
      TRIPPED:      next_state = TRIPPED;
      default:      next_state = INIT;
    endcase
  end

  // Relay and ready are registered from next_state so they follow the FSM
  // on the same edge it changes state.
  always_ff @(posedge clk) begin
    if (Power_on_Reset) begin
      state         <= INIT;
      To_SDC_relais <= 1'b0;
      SDC_is_Ready  <= 1'b0;
      trip_cause    <= NONE;
      mode_cap      <= 1'b0;
    end else begin
      state         <= next_state;
      To_SDC_relais <= (next_state == CLOSED);
      SDC_is_Ready  <= (next_state == ARMED) || (next_state == CLOSED);
      if (trip_now)
        trip_cause <= fault_cause;
      if (close_now)
        mode_cap <= mode_s;
    end
  end

  assign SDC_state  = state;
  assign Trip_cause = trip_cause;

`ifdef SDC_FAULT_LOG_EN
  localparam int FW = cnt_w(N_LOOPS);

  logic [FW-1:0]         first_open, fault_loop;
  logic [TRIP_CNT_W-1:0] trip_count;

  always_comb begin
    first_open = '0;
    for (int i = N_LOOPS - 1; i >= 0; i--)
      if (!loops_f[i]) first_open = FW'(i);
  end

  always_ff @(posedge clk) begin
    if (Power_on_Reset) begin
      fault_loop <= '0;
      trip_count <= '0;
    end else if (trip_now) begin
      if (fault_cause == LOOP)
        fault_loop <= first_open;
      if (trip_count != {TRIP_CNT_W{1'b1}})
        trip_count <= trip_count + TRIP_CNT_W'(1);
    end
  end

  assign First_fault_loop = fault_loop;
  assign Trip_count       = trip_count;
`endif

endmodule

// File: tb/tb_sdc_supervisor.sv
// Directed self-checking bench for sdc_supervisor (default parameters).
module tb_sdc_supervisor;
  import sdc_pkg::*;

  logic       clk = 1'b0;
  logic       Power_on_Reset;
  logic       AS_close_SDC;
  logic       AS_driving_mode;
  logic       TS_Activation_Button_cockpit;
  logic       TS_Activation_Button_external;
  logic       Watchdog;
  logic [3:0] Shutdown_circuit;
  logic       To_SDC_relais;
  logic       SDC_is_Ready;
  logic [2:0] SDC_state;
  logic [2:0] Trip_cause;
`ifdef SDC_FAULT_LOG_EN
  logic [cnt_w(4)-1:0] First_fault_loop;
  logic [7:0]          Trip_count;
`endif

  int checks = 0;
  int errors = 0;
  bit wd_run = 1'b0;
  int wd_div = 0;

  sdc_supervisor dut (
    .clk                           (clk),
    .Power_on_Reset                (Power_on_Reset),
    .AS_close_SDC                  (AS_close_SDC),
    .AS_driving_mode               (AS_driving_mode),
    .TS_Activation_Button_cockpit  (TS_Activation_Button_cockpit),
    .TS_Activation_Button_external (TS_Activation_Button_external),
    .Watchdog                      (Watchdog),
    .Shutdown_circuit              (Shutdown_circuit),
    .To_SDC_relais                 (To_SDC_relais),
    .SDC_is_Ready                  (SDC_is_Ready),
    .SDC_state                     (SDC_state),
    .Trip_cause                    (Trip_cause)
`ifdef SDC_FAULT_LOG_EN
    ,
    .First_fault_loop              (First_fault_loop),
    .Trip_count                    (Trip_count)
`endif
  );

  always #5 clk = ~clk;

  // Advance n clocks; inputs change and outputs are sampled 1 time unit
  // after each rising edge. The watchdog pin toggles every 100 clocks.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (wd_run) begin
        wd_div++;
        if (wd_div >= 100) begin
          wd_div   = 0;
          Watchdog = ~Watchdog;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic reset_and_close();
    Power_on_Reset                = 1'b1;
    Shutdown_circuit              = 4'hF;
    AS_driving_mode               = 1'b0;
    TS_Activation_Button_cockpit  = 1'b1;
    TS_Activation_Button_external = 1'b0;
    AS_close_SDC                  = 1'b1;
    wd_run                        = 1'b1;
    wd_div                        = 0;
    tick(2);
    Power_on_Reset = 1'b0;
    for (int i = 0; i < 60 && SDC_is_Ready !== 1'b1; i++) tick(1);
    check("arm_wait", 8'(SDC_is_Ready), 8'd1);
    TS_Activation_Button_cockpit = 1'b0;
    tick(1);
    TS_Activation_Button_cockpit = 1'b1;
    for (int i = 0; i < 30 && To_SDC_relais !== 1'b1; i++) tick(1);
    check("close_wait", 8'(To_SDC_relais), 8'd1);
  endtask

  initial begin
    Power_on_Reset                = 1'b1;
    AS_close_SDC                  = 1'b1;
    AS_driving_mode               = 1'b0;
    TS_Activation_Button_cockpit  = 1'b1;
    TS_Activation_Button_external = 1'b0;
    Watchdog                      = 1'b0;
    Shutdown_circuit              = 4'hF;
    tick(3);
    check("reset_relay", 8'(To_SDC_relais), 8'd0);
    check("reset_ready", 8'(SDC_is_Ready), 8'd0);
    check("reset_state", 8'(SDC_state), 8'(INIT));
    check("reset_cause", 8'(Trip_cause), 8'(NONE));
`ifdef SDC_FAULT_LOG_EN
    check("reset_ffl", 8'(First_fault_loop), 8'd0);
    check("reset_tcnt", Trip_count, 8'd0);
`endif

    // 2 sync + 16 debounce edges make loops_ok, one more edge reaches ARMED
    Power_on_Reset = 1'b0;
    wd_run         = 1'b1;
    tick(18);
    check("ready_early", 8'(SDC_is_Ready), 8'd0);
    check("state_waiting", 8'(SDC_state), 8'(WAIT_HEALTHY));
    tick(1);
    check("ready_armed", 8'(SDC_is_Ready), 8'd1);
    check("state_armed", 8'(SDC_state), 8'(ARMED));
    check("relay_armed", 8'(To_SDC_relais), 8'd0);

    // Button held since reset never counts as released
    tick(20);
    check("stuck_state", 8'(SDC_state), 8'(ARMED));
    check("stuck_relay", 8'(To_SDC_relais), 8'd0);

    // One-clock release, then hold: closes on the 10th edge after re-press
    TS_Activation_Button_cockpit = 1'b0;
    tick(1);
    TS_Activation_Button_cockpit = 1'b1;
    tick(9);
    check("hold_state", 8'(SDC_state), 8'(ARMED));
    check("hold_relay", 8'(To_SDC_relais), 8'd0);
    tick(1);
    check("closed_state", 8'(SDC_state), 8'(CLOSED));
    check("closed_relay", 8'(To_SDC_relais), 8'd1);
    check("closed_ready", 8'(SDC_is_Ready), 8'd1);

    // Loop 2 drops for one clock: relay opens on the 4th edge from the pin
    Shutdown_circuit = 4'b1011;
    tick(1);
    Shutdown_circuit = 4'hF;
    tick(2);
    check("loop_relay_still", 8'(To_SDC_relais), 8'd1);
    tick(1);
    check("loop_relay", 8'(To_SDC_relais), 8'd0);
    check("loop_state", 8'(SDC_state), 8'(TRIPPED));
    check("loop_cause", 8'(Trip_cause), 8'(LOOP));
    check("loop_ready", 8'(SDC_is_Ready), 8'd0);
`ifdef SDC_FAULT_LOG_EN
    check("loop_ffl", 8'(First_fault_loop), 8'd2);
    check("loop_tcnt", Trip_count, 8'd1);
`endif
    tick(40);
    check("sticky_state", 8'(SDC_state), 8'(TRIPPED));
    check("sticky_cause", 8'(Trip_cause), 8'(LOOP));
    check("sticky_relay", 8'(To_SDC_relais), 8'd0);

    Power_on_Reset = 1'b1;
    tick(1);
    check("rst_mid_state", 8'(SDC_state), 8'(INIT));
    check("rst_mid_cause", 8'(Trip_cause), 8'(NONE));

    // Watchdog stalls; AS_close_SDC drops on the same cycle wd_ok falls
    reset_and_close();
    wd_run   = 1'b0;
    Watchdog = ~Watchdog;
    tick(1001);
    AS_close_SDC = 1'b0;
    tick(2);
    check("wd_state_still", 8'(SDC_state), 8'(CLOSED));
    tick(1);
    check("wd_state", 8'(SDC_state), 8'(TRIPPED));
    check("wd_cause", 8'(Trip_cause), 8'(WDOG));
    check("wd_relay", 8'(To_SDC_relais), 8'd0);

    reset_and_close();
    AS_driving_mode = 1'b1;
    tick(2);
    check("mode_state_still", 8'(SDC_state), 8'(CLOSED));
    tick(1);
    check("mode_state", 8'(SDC_state), 8'(TRIPPED));
    check("mode_cause", 8'(Trip_cause), 8'(MODE));

    reset_and_close();
    AS_close_SDC = 1'b0;
    tick(2);
    check("asopen_relay_still", 8'(To_SDC_relais), 8'd1);
    tick(1);
    check("asopen_state", 8'(SDC_state), 8'(TRIPPED));
    check("asopen_cause", 8'(Trip_cause), 8'(AS_OPEN));

    // Loop 1 bouncing every 5 clocks never satisfies the debounce
    Power_on_Reset   = 1'b1;
    AS_close_SDC     = 1'b1;
    AS_driving_mode  = 1'b0;
    Shutdown_circuit = 4'hF;
    wd_div           = 0;
    tick(2);
    Power_on_Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(5);
      Shutdown_circuit[1] = ~Shutdown_circuit[1];
    end
    check("bounce_state", 8'(SDC_state), 8'(WAIT_HEALTHY));
    check("bounce_ready", 8'(SDC_is_Ready), 8'd0);
    Shutdown_circuit = 4'hF;
    for (int i = 0; i < 40 && SDC_is_Ready !== 1'b1; i++) tick(1);
    check("bounce_recover", 8'(SDC_state), 8'(ARMED));

`ifdef SDC_FAULT_LOG_EN
    reset_and_close();
    check("log_tcnt_clr", Trip_count, 8'd0);
    Shutdown_circuit = 4'b0101;
    tick(1);
    Shutdown_circuit = 4'hF;
    tick(3);
    check("log_state", 8'(SDC_state), 8'(TRIPPED));
    check("log_ffl", 8'(First_fault_loop), 8'd1);
    check("log_tcnt", Trip_count, 8'd1);
    tick(10);
    check("log_ffl_hold", 8'(First_fault_loop), 8'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
